// File: rtl/jk_sync_down_counter_pkg.sv
// Shared JK flip-flop mode encodings, common to the up and down counters.
// A JK mode is packed as {J, K}.
package jk_sync_down_counter_pkg;

    localparam logic [1:0] JK_HOLD   = 2'b00;
    localparam logic [1:0] JK_RESET  = 2'b01;
    localparam logic [1:0] JK_SET    = 2'b10;
    localparam logic [1:0] JK_TOGGLE = 2'b11;

    // Forces a bit to a known value: SET for 1, RESET for 0.
    function automatic logic [1:0] jk_force(input logic bit_val);
        return bit_val ? JK_SET : JK_RESET;
    endfunction

endpackage

// File: rtl/jk_ff_sync.sv
// Single-bit JK flip-flop with a synchronous, active-high clear.
module jk_ff_sync
    import jk_sync_down_counter_pkg::*;
(
    input  logic clk,
    input  logic clr,
    input  logic j,
    input  logic k,
    output logic q,
    output logic qb
);

    always_ff @(posedge clk) begin
        if (clr) begin
            q <= 1'b0;
        end else begin
            case ({j, k})
                JK_HOLD:   q <= q;
                JK_RESET:  q <= 1'b0;
                JK_SET:    q <= 1'b1;
                JK_TOGGLE: q <= ~q;
                default:   q <= q;
            endcase
        end
    end

    assign qb = ~q;

endmodule

// File: rtl/jk_sync_down_counter.sv
// Synchronous loadable, cascadable down counter built from JK flops sharing one clock.
// Priority per edge: clr > load > en > hold.
module jk_sync_down_counter
    import jk_sync_down_counter_pkg::*;
#(
    parameter int WIDTH    = 3,
    parameter int MODULUS  = 8,
    parameter int ONE_SHOT = 0
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb,
    output logic             zero,
    output logic             bout,
    output logic             done
);

    localparam logic [WIDTH-1:0] MAX_COUNT = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] q_bits;
    logic [WIDTH-1:0] qb_bits;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] borrow;
    logic [WIDTH-1:0] j_vec;
    logic [WIDTH-1:0] k_vec;
    logic             is_zero;
    logic             done_q;

    assign is_zero  = (q_bits == '0);
    assign load_val = (d > MAX_COUNT) ? MAX_COUNT : d;

    // Bit i toggles on a decrement only when every lower bit is zero.
    always_comb begin
        logic run;
        run = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            borrow[i] = run;
            run       = run & qb_bits[i];
        end
    end

    always_comb begin
        logic [1:0] jk;
        j_vec = '0;
        k_vec = '0;
        for (int i = 0; i < WIDTH; i++) begin
            jk = JK_HOLD;
            if (load) begin
                jk = jk_force(load_val[i]);
            end else if (en && is_zero) begin
                jk = (ONE_SHOT != 0) ? JK_HOLD : jk_force(MAX_COUNT[i]);
            end else if (en && borrow[i]) begin
                jk = JK_TOGGLE;
            end
            j_vec[i] = jk[1];
            k_vec[i] = jk[0];
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        jk_ff_sync u_ff (
            .clk (clk),
            .clr (clr),
            .j   (j_vec[i]),
            .k   (k_vec[i]),
            .q   (q_bits[i]),
            .qb  (qb_bits[i])
        );
    end

    // Sticky terminal flag for one-shot mode; cleared by clr or load.
    always_ff @(posedge clk) begin
        if (clr) begin
            done_q <= 1'b0;
        end else if (load) begin
            done_q <= 1'b0;
        end else if ((ONE_SHOT != 0) && en && is_zero) begin
            done_q <= 1'b1;
        end
    end

    assign q    = q_bits;
    assign qb   = qb_bits;
    assign zero = is_zero;
    assign bout = en & is_zero & ~load & ~clr;
    assign done = (ONE_SHOT != 0) ? done_q : 1'b0;

endmodule

// File: tb/tb_jk_sync_down_counter.sv
// Self-checking bench: four counter configurations driven by one stimulus stream,
// checked every cycle against an arithmetic model plus directed literal expectations.
module tb_jk_sync_down_counter;

    logic       clk;
    logic       clr;
    logic       en;
    logic       load;
    logic [2:0] d;

    logic [2:0] q_a, qb_a, q_b, qb_b, q_c, qb_c, q_lo, qb_lo, q_hi, qb_hi;
    logic       zero_a, bout_a, done_a;
    logic       zero_b, bout_b, done_b;
    logic       zero_c, bout_c, done_c;
    logic       zero_lo, bout_lo, done_lo;
    logic       zero_hi, bout_hi, done_hi;

    int vectors    = 0;
    int miscompares = 0;

    int  ma, mb, mc, mcas;
    bit  mdc;
    bit  model_valid = 1'b0;

    int exp_free[4]  = '{1, 0, 7, 6};
    int exp_fbout[4] = '{0, 1, 0, 0};
    int exp_mod5[6]  = '{3, 2, 1, 0, 4, 3};
    int exp_os_q[5]  = '{1, 0, 0, 0, 0};
    int exp_os_d[5]  = '{0, 0, 1, 1, 1};

    jk_sync_down_counter #(.WIDTH(3), .MODULUS(8), .ONE_SHOT(0)) u_mod8 (
        .clk(clk), .clr(clr), .en(en), .load(load), .d(d),
        .q(q_a), .qb(qb_a), .zero(zero_a), .bout(bout_a), .done(done_a));

    jk_sync_down_counter #(.WIDTH(3), .MODULUS(5), .ONE_SHOT(0)) u_mod5 (
        .clk(clk), .clr(clr), .en(en), .load(load), .d(d),
        .q(q_b), .qb(qb_b), .zero(zero_b), .bout(bout_b), .done(done_b));

    jk_sync_down_counter #(.WIDTH(3), .MODULUS(8), .ONE_SHOT(1)) u_oneshot (
        .clk(clk), .clr(clr), .en(en), .load(load), .d(d),
        .q(q_c), .qb(qb_c), .zero(zero_c), .bout(bout_c), .done(done_c));

    jk_sync_down_counter #(.WIDTH(3), .MODULUS(8), .ONE_SHOT(0)) u_cas_lo (
        .clk(clk), .clr(clr), .en(en), .load(load), .d(d),
        .q(q_lo), .qb(qb_lo), .zero(zero_lo), .bout(bout_lo), .done(done_lo));

    jk_sync_down_counter #(.WIDTH(3), .MODULUS(8), .ONE_SHOT(0)) u_cas_hi (
        .clk(clk), .clr(clr), .en(bout_lo), .load(load), .d(d),
        .q(q_hi), .qb(qb_hi), .zero(zero_hi), .bout(bout_hi), .done(done_hi));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic c, input logic l, input logic e,
                                 input logic [2:0] dv);
        @(negedge clk);
        clr  = c;
        load = l;
        en   = e;
        d    = dv;
        @(posedge clk);
        #2;
    endtask

    function automatic int next_count(input int cur, input int modulus, input bit one_shot,
                                      input bit c, input bit l, input bit e, input int dv);
        if (c) return 0;
        if (l) return (dv > modulus - 1) ? modulus - 1 : dv;
        if (e) begin
            if (cur == 0) return one_shot ? 0 : modulus - 1;
            return cur - 1;
        end
        return cur;
    endfunction

    // Model advances on every edge, then outputs are compared 1 time unit later.
    always @(posedge clk) begin
        if (clr) model_valid = 1'b1;
        if (clr || load)           mdc = 1'b0;
        else if (en && mc == 0)    mdc = 1'b1;
        ma = next_count(ma, 8, 1'b0, clr, load, en, int'(d));
        mb = next_count(mb, 5, 1'b0, clr, load, en, int'(d));
        mc = next_count(mc, 8, 1'b1, clr, load, en, int'(d));
        if (clr)       mcas = 0;
        else if (load) mcas = int'(d) * 9;
        else if (en)   mcas = (mcas + 63) % 64;
        #1;
        if (model_valid) begin
            checkOutput("mod8.q",     q_a,    ma);
            checkOutput("mod8.qb",    qb_a,   (~ma) & 7);
            checkOutput("mod8.zero",  zero_a, ma == 0);
            checkOutput("mod8.bout",  bout_a, en && ma == 0 && !load && !clr);
            checkOutput("mod8.done",  done_a, 0);
            checkOutput("mod5.q",     q_b,    mb);
            checkOutput("mod5.bout",  bout_b, en && mb == 0 && !load && !clr);
            checkOutput("os.q",       q_c,    mc);
            checkOutput("os.done",    done_c, mdc);
            checkOutput("os.bout",    bout_c, en && mc == 0 && !load && !clr);
            checkOutput("cas.count",  {q_hi, q_lo}, mcas);
            checkOutput("cas.bout",   bout_hi, en && mcas == 0 && !load && !clr);
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        clr  = 1'b1;
        load = 1'b1;
        en   = 1'b1;
        d    = 3'd5;

        // Reset held with every other input active.
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b1, 3'd5);
            checkOutput("rst.q",    q_a,    0);
            checkOutput("rst.qb",   qb_a,   7);
            checkOutput("rst.zero", zero_a, 1);
            checkOutput("rst.bout", bout_a, 0);
            checkOutput("rst.done", done_c, 0);
        end
        applyStimulus(1'b0, 1'b0, 1'b1, 3'd0);
        checkOutput("rel.mod8", q_a, 7);
        checkOutput("rel.mod5", q_b, 4);
        checkOutput("rel.os.q", q_c, 0);
        checkOutput("rel.os.done", done_c, 1);
        checkOutput("rel.cas", {q_hi, q_lo}, 63);

        // Free-running wrap through zero.
        applyStimulus(1'b0, 1'b1, 1'b0, 3'd2);
        checkOutput("free.load", q_a, 2);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 3'd0);
            checkOutput("free.q",    q_a,    exp_free[i]);
            checkOutput("free.bout", bout_a, exp_fbout[i]);
        end

        // Non-power-of-two modulus with load clamp.
        applyStimulus(1'b0, 1'b1, 1'b0, 3'd7);
        checkOutput("mod5.clamp", q_b, 4);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 3'd0);
            checkOutput("mod5.seq", q_b, exp_mod5[i]);
        end

        // Priority: load beats en, clr beats load.
        applyStimulus(1'b0, 1'b1, 1'b0, 3'd3);
        checkOutput("prio.pre", q_a, 3);
        applyStimulus(1'b0, 1'b1, 1'b1, 3'd6);
        checkOutput("prio.load", q_a, 6);
        applyStimulus(1'b1, 1'b1, 1'b1, 3'd6);
        checkOutput("prio.clr", q_a, 0);

        // One-shot parks at zero with sticky done.
        applyStimulus(1'b0, 1'b1, 1'b0, 3'd2);
        checkOutput("os.load", q_c, 2);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 3'd0);
            checkOutput("os.seq.q",    q_c,    exp_os_q[i]);
            checkOutput("os.seq.done", done_c, exp_os_d[i]);
        end
        checkOutput("os.parked.bout", bout_c, 1);
        applyStimulus(1'b0, 1'b1, 1'b0, 3'd1);
        checkOutput("os.reload.q",    q_c,    1);
        checkOutput("os.reload.done", done_c, 0);

        // Two-stage cascade acting as one 6-bit counter.
        applyStimulus(1'b1, 1'b0, 1'b0, 3'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 3'd0);
        checkOutput("cas.load", {q_hi, q_lo}, 0);
        for (int k = 1; k <= 10; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 3'd0);
            checkOutput("cas.seq", {q_hi, q_lo}, (64 - k) % 64);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 3'd0);
        checkOutput("cas.hold", {q_hi, q_lo}, 54);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
